// File: rtl/button_debouncer_if.sv
// Button signal bundle between the raw pad side and the debouncer.
// master drives the raw button; slave (the debouncer) returns the clean level and press strobe.
interface button_debouncer_if;
  logic btn_in;
  logic btn_level;
  logic btn_pulse;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_pulse
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_pulse
  );
endinterface

// File: rtl/button_debouncer.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level debounce FSM, registered level and press strobe.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat strobes (REPEAT_DELAY / REPEAT_PERIOD).
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY  = 32,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst,
  button_debouncer_if.slave bus
);

  localparam int unsigned     CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Repeat intervals below 2 would let two strobes land in adjacent cycles.
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("button_debouncer: STABLE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
    $error("button_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned   RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   HW          = $clog2(RMAX);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
    hold_d  = hold_q;
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef AUTO_REPEAT_EN
        // One counter serves both intervals; rep_q selects first-delay vs. period.
        else if (hold_q == (rep_q ? PERIOD_LAST : DELAY_LAST)) begin
          pulse_d = 1'b1;
          hold_d  = '0;
          rep_d   = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
`endif
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef AUTO_REPEAT_EN
    if (state_d == PRESSED && state_q != PRESSED) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end
`endif
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      hold_q  <= '0;
      rep_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
`ifdef AUTO_REPEAT_EN
      hold_q  <= hold_d;
      rep_q   <= rep_d;
`endif
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboarded bench for button_debouncer: expected strobe edges are queued when a press is driven
// and matched against each observed btn_pulse; btn_level is checked at the specified edges.
module tb_button_debouncer;
  localparam int unsigned S  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 4;
  localparam int          L  = S + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  bit   prev_pulse = 1'b0;
  int   t0, t1, tf, r;

  button_debouncer_if bus();

  button_debouncer #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected strobes for a press entering PRESSED at edge e whose button is released after edge tr.
  task automatic push_hold(input int e, input int tr);
    exp_q.push_back(e);
`ifdef AUTO_REPEAT_EN
    for (int n = e + int'(RD); n <= tr + 2; n += int'(RP)) exp_q.push_back(n);
`else
    if (tr < 0) exp_q.push_back(-1);
`endif
  endtask

  always @(negedge clk) begin
    if (bus.btn_pulse === 1'b1) begin
      check("pulse_b2b", int'(prev_pulse), 0);
      if (exp_q.size() == 0) check("pulse_spurious", cyc, -1);
      else                   check("pulse_edge", cyc, exp_q.pop_front());
    end
    prev_pulse = (bus.btn_pulse === 1'b1);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.btn_in = 1'b0;
    rst = 1'b0;
    tick(3);
    check("rst_level", int'(bus.btn_level), 0);
    check("rst_pulse", int'(bus.btn_pulse), 0);
    rst = 1'b1;
    tick(3);

    // Clean press held 20 cycles, then clean release
    t0 = cyc;
    bus.btn_in = 1'b1;
    push_hold(t0 + L, t0 + 20);
    tick(L - 1);
    check("press_lvl_early", int'(bus.btn_level), 0);
    tick(1);
    check("press_lvl", int'(bus.btn_level), 1);
    tick(20 - L);
    t1 = cyc;
    bus.btn_in = 1'b0;
    tick(L - 1);
    check("rel_lvl_hold", int'(bus.btn_level), 1);
    tick(1);
    check("rel_lvl", int'(bus.btn_level), 0);
    tick(4);
    check("sb_clean", exp_q.size(), 0);

    // Bounce: toggles every 2 clocks for 12 clocks, then stays high
    for (int i = 0; i < 12; i++) begin
      bus.btn_in = ((i % 4) < 2);
      tick(1);
    end
    tf = cyc;
    bus.btn_in = 1'b1;
    push_hold(tf + L, tf + 15);
    tick(L - 1);
    check("bounce_lvl_early", int'(bus.btn_level), 0);
    tick(1);
    check("bounce_lvl", int'(bus.btn_level), 1);
    tick(15 - L);
    bus.btn_in = 1'b0;
    tick(L + 3);
    check("bounce_lvl_rel", int'(bus.btn_level), 0);
    check("sb_bounce", exp_q.size(), 0);

    // Short glitch of 3 clocks must be rejected entirely
    bus.btn_in = 1'b1;
    tick(3);
    bus.btn_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("glitch_lvl", int'(bus.btn_level), 0);
    end

    // Release with bounce: low 2, high 1, then low
    t0 = cyc;
    bus.btn_in = 1'b1;
    push_hold(t0 + L, t0 + L + 3);
    tick(L + 3);
    check("rb_pressed", int'(bus.btn_level), 1);
    bus.btn_in = 1'b0;
    tick(2);
    bus.btn_in = 1'b1;
    tick(1);
    bus.btn_in = 1'b0;
    tf = cyc;
    check("rb_lvl_bounce", int'(bus.btn_level), 1);
    for (int i = 1; i < L; i++) begin
      tick(1);
      check("rb_lvl_hold", int'(bus.btn_level), 1);
    end
    tick(1);
    check("rb_lvl_fall", int'(bus.btn_level), 0);
    tick(3);
    check("sb_relbounce", exp_q.size(), 0);

    // Reset mid-qualify with the button held, then reset while PRESSED
    t0 = cyc;
    bus.btn_in = 1'b1;
    tick(4);
    rst = 1'b0;
    #1;
    check("rstq_level", int'(bus.btn_level), 0);
    check("rstq_pulse", int'(bus.btn_pulse), 0);
    tick(2);
    rst = 1'b1;
    r = cyc;
    push_hold(r + L, r + 12);
    tick(L - 1);
    check("rstq_lvl_early", int'(bus.btn_level), 0);
    tick(1);
    check("rstq_lvl", int'(bus.btn_level), 1);
    tick(12 - L);
    rst = 1'b0;
    #1;
    check("rstp_level", int'(bus.btn_level), 0);
    bus.btn_in = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(5);
    check("sb_reset", exp_q.size(), 0);

    // Long hold of 30 clocks: single strobe, or repeats when enabled
    t0 = cyc;
    bus.btn_in = 1'b1;
    push_hold(t0 + L, t0 + 30);
    tick(30);
    bus.btn_in = 1'b0;
    tick(L + 3);
    check("hold_lvl_rel", int'(bus.btn_level), 0);
    tick(4);
    check("sb_hold", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw mechanical pushbutton for the calculator's digit/operand counters. Synchronises the asynchronous pad signal, rejects contact bounce by requiring a stable level for a programmable number of clocks, and emits a clean debounced level plus a single-cycle press pulse. The pulse drives the increment input of the downstream BCD digit counter, which therefore sees exactly one strobe per physical press.

## Interface
- STABLE_CYCLES, default 16: clocks a synchronised level must hold before it is accepted; legal range ≥ 2.
- REPEAT_DELAY, default 32: clocks from accepted press to first auto-repeat pulse; used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, default 8: clocks between subsequent auto-repeat pulses; used only with AUTO_REPEAT_EN.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset; rst = 0 clears all state immediately.
- btn_in  input  1  raw button, asynchronous to clk, active-high.
- btn_level  output  1  debounced button level.
- btn_pulse  output  1  one-clock strobe on each accepted press, and on each repeat when enabled.

## Operation
- Two-flop synchroniser (sync1, sync2) on btn_in, both reset to 0. The FSM sees only sync2.
- Debounce counter width is $clog2(STABLE_CYCLES); it clears on every state change.
- FSM states, reset state IDLE:
  - IDLE (btn_level = 0): sync2 = 1 → PRESS_WAIT, cnt = 0.
  - PRESS_WAIT: sync2 = 0 → IDLE, no pulse; sync2 = 1 and cnt = STABLE_CYCLES-1 → PRESSED, assert btn_pulse; otherwise cnt+1.
  - PRESSED (btn_level = 1): sync2 = 0 → RELEASE_WAIT, cnt = 0.
  - RELEASE_WAIT (btn_level stays 1): sync2 = 1 → PRESSED, no new pulse; sync2 = 0 and cnt = STABLE_CYCLES-1 → IDLE; otherwise cnt+1.
- btn_level and btn_pulse are registered outputs; both are 0 on reset.
- btn_pulse is high for exactly one clock per qualifying event and is never high two cycles in a row.
- Release never produces a pulse.
- Reset mid-operation (any state) returns the block to IDLE with the synchroniser cleared. A button still held after rst rises is treated as a new press and takes the full latency.

## Timing
- Edge 1 is the first clk edge that samples btn_in = 1. sync2 = 1 after edge 2, PRESS_WAIT after edge 3, PRESSED after edge STABLE_CYCLES+3.
- btn_pulse and btn_level both rise in the cycle after edge STABLE_CYCLES+3.
- Release latency is symmetric: btn_level falls in the cycle after edge STABLE_CYCLES+3, counted from the first edge that samples btn_in = 0.
- Any opposite-level sample during a WAIT state restarts qualification. Latency is therefore measured from the last transition.
- Minimum press accepted: btn_in stable for STABLE_CYCLES+1 consecutive samples.

## Configuration
- AUTO_REPEAT_EN defined: a hold timer runs while in PRESSED and restarts at 0 on every entry to PRESSED, including re-entry from RELEASE_WAIT.
  - btn_pulse fires REPEAT_DELAY clocks after entering PRESSED, then every REPEAT_PERIOD clocks while the button stays in PRESSED.
  - Moving to RELEASE_WAIT freezes and discards the timer.
- AUTO_REPEAT_EN undefined: the hold timer and the REPEAT_* logic are absent. Exactly one pulse per accepted press, regardless of hold time.

## Test plan
- Clean press (STABLE_CYCLES = 4): btn_in 0→1 at edge 1, held for 20 cycles → btn_pulse high only in the cycle after edge 7; btn_level = 1 from edge 7 onward.
- Bounce: btn_in toggles every 2 clocks for 12 clocks, then stays high → exactly one btn_pulse, 7 edges after the final rising transition; no earlier pulse.
- Short glitch: btn_in high for 3 clocks, then low (STABLE_CYCLES = 4) → btn_pulse and btn_level stay 0 throughout.
- Release with bounce: from PRESSED, btn_in low 2 clocks, high 1 clock, then low → btn_level stays 1 through the bounce and falls 7 edges after the final falling transition; btn_pulse stays 0.
- Reset mid-qualify: rst driven to 0 while in PRESS_WAIT with btn_in held high → btn_level and btn_pulse are 0 immediately. After rst returns to 1, btn_pulse appears in the cycle after edge 7, counted from the first post-reset sampling edge.
- AUTO_REPEAT_EN (STABLE_CYCLES = 4, REPEAT_DELAY = 8, REPEAT_PERIOD = 4): btn_in held for 30 clocks → pulses after edges 7, 15, 19, 23, 27, 31; none after release.
